// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer. It issues one word fetch at a time to
// instruction memory, latches the returned word into the instruction register,
// and waits for unit_control to retire that instruction before it advances the
// PC and fetches again. A fetched halt word (bits [31:24] == HALT_WORD) stops
// fetching until reset.
//
// state | meaning
// ------+--------------------------------------------------------------------
// IDLE  | held in reset; leaves on the first clock edge after release
// REQ   | im_req high, im_addr = pc, waiting for im_ack
// HOLD  | instr valid, waiting for the w_pc retire pulse
// HALT  | halt word fetched; fetching stopped until reset
//
// Ports
//   clk          in   1   system clock, rising-edge active
//   rst_n        in   1   asynchronous active-low reset
//   w_pc         in   1   retire pulse for the current instruction
//   s_mxpc       in   1   next-PC select with w_pc: 0 = pc+1, 1 = pc_tgt
//   pc_tgt       in   32  branch/jump target
//   im_addr      out  32  instruction memory word address (same as pc)
//   im_req       out  1   fetch request
//   im_ack       in   1   memory acknowledge, im_data valid this cycle
//   im_data      in   32  instruction word from memory
//   instr        out  32  instruction register
//   instr_type   out  3   instr[31:29]
//   op           out  5   instr[28:24]
//   instr_valid  out  1   instr holds a fetched, not-yet-retired instruction
//   pc           out  32  address of instr / word being fetched
//   fetch_cnt    out  16  number of accepted fetches (wraps)
//   halted       out  1   halt word fetched
//   err          out  1   sticky protocol error (w_pc outside HOLD/HALT)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [7:0]  HALT_WORD = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_pc,
    input  logic        s_mxpc,
    input  logic [31:0] pc_tgt,
    output logic [31:0] im_addr,
    output logic        im_req,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    output logic [31:0] instr,
    output logic [2:0]  instr_type,
    output logic [4:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [15:0] fetch_cnt,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        retire;
    logic        proto_err;
    logic        is_halt;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [15:0] cnt_q;
    logic        halted_q;
    logic        err_q;

    assign is_halt = (im_data[31:24] == HALT_WORD);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and datapath strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        retire    = 1'b0;
        proto_err = 1'b0;
        im_req    = 1'b0;

        case (state)
            S_IDLE: begin
                // IDLE only lasts the first cycle after reset release, so a
                // stray w_pc here is flagged but never blocks the move to REQ.
                state_nxt = S_REQ;
                proto_err = w_pc;
            end

            S_REQ: begin
                im_req = 1'b1;
                if (w_pc) begin
                    // Nothing is outstanding to retire. The cycle is treated as
                    // a no-op (state and pc frozen) and the request stays up, so
                    // a concurrent acknowledge is not taken.
                    proto_err = 1'b1;
                end else if (im_ack) begin
                    accept    = 1'b1;
                    state_nxt = is_halt ? S_HALT : S_HOLD;
                end
            end

            S_HOLD: begin
                if (w_pc) begin
                    retire    = 1'b1;
                    state_nxt = S_REQ;
                end
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= PC_RESET;
            instr_q  <= 32'h0000_0000;
            valid_q  <= 1'b0;
            cnt_q    <= 16'h0000;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                instr_q  <= im_data;
                valid_q  <= 1'b1;
                cnt_q    <= cnt_q + 16'd1;
                halted_q <= is_halt;
            end

            if (retire) begin
                pc_q    <= s_mxpc ? pc_tgt : (pc_q + 32'd1);
                valid_q <= 1'b0;
            end

            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pc          = pc_q;
    assign im_addr     = pc_q;
    assign instr       = instr_q;
    assign instr_type  = instr_q[31:29];
    assign op          = instr_q[28:24];
    assign instr_valid = valid_q;
    assign fetch_cnt   = cnt_q;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        w_pc;
    logic        s_mxpc;
    logic [31:0] pc_tgt;
    logic [31:0] im_addr;
    logic        im_req;
    logic        im_ack;
    logic [31:0] im_data;
    logic [31:0] instr;
    logic [2:0]  instr_type;
    logic [4:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [15:0] fetch_cnt;
    logic        halted;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_pc        (w_pc),
        .s_mxpc      (s_mxpc),
        .pc_tgt      (pc_tgt),
        .im_addr     (im_addr),
        .im_req      (im_req),
        .im_ack      (im_ack),
        .im_data     (im_data),
        .instr       (instr),
        .instr_type  (instr_type),
        .op          (op),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fetch_cnt   (fetch_cnt),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // advance one rising edge, then settle before driving/sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        w_pc   = 1'b0;
        s_mxpc = 1'b0;
        pc_tgt = 32'h0;
        im_ack = 1'b1;          // ack during reset must be ignored
        im_data = 32'h2300_0000;

        step(); step();
        chk("rst_pc",     pc,          32'h0);
        chk("rst_instr",  instr,       32'h0);
        chk("rst_valid",  {31'h0, instr_valid}, 32'h0);
        chk("rst_imreq",  {31'h0, im_req},      32'h0);
        chk("rst_cnt",    {16'h0, fetch_cnt},   32'h0);
        chk("rst_halted", {31'h0, halted},      32'h0);
        chk("rst_err",    {31'h0, err},         32'h0);

        // release: first edge IDLE -> REQ
        im_ack = 1'b0;
        rst_n  = 1'b1;
        step();
        chk("req_imreq", {31'h0, im_req}, 32'h1);
        chk("req_addr",  im_addr, 32'h0);

        // ack on first REQ cycle
        im_ack = 1'b1; im_data = 32'h2300_0000;
        step();
        im_ack = 1'b0;
        chk("f1_valid", {31'h0, instr_valid}, 32'h1);
        chk("f1_type",  {29'h0, instr_type},  32'h1);
        chk("f1_op",    {27'h0, op},          32'h3);
        chk("f1_cnt",   {16'h0, fetch_cnt},   32'h1);
        chk("f1_imreq", {31'h0, im_req},      32'h0);

        // hold without retire
        step();
        chk("hold_valid", {31'h0, instr_valid}, 32'h1);
        chk("hold_pc",    pc, 32'h0);

        // retire sequential
        w_pc = 1'b1; s_mxpc = 1'b0;
        step();
        w_pc = 1'b0;
        chk("seq_pc",    pc, 32'h1);
        chk("seq_imreq", {31'h0, im_req}, 32'h1);
        chk("seq_valid", {31'h0, instr_valid}, 32'h0);

        // delayed ack: 3 cycles waiting
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dly_imreq", {31'h0, im_req}, 32'h1);
            chk("dly_addr",  im_addr, 32'h1);
            chk("dly_instr", instr, 32'h2300_0000);
        end
        im_ack = 1'b1; im_data = 32'h1234_5678;
        step();
        im_ack = 1'b0;
        chk("dly_instr_upd", instr, 32'h1234_5678);
        chk("dly_cnt", {16'h0, fetch_cnt}, 32'h2);

        // retire to target
        w_pc = 1'b1; s_mxpc = 1'b1; pc_tgt = 32'h40;
        step();
        w_pc = 1'b0; s_mxpc = 1'b0;
        chk("tgt_addr",  im_addr, 32'h40);
        chk("tgt_imreq", {31'h0, im_req}, 32'h1);

        // w_pc during REQ -> error, pc unchanged
        w_pc = 1'b1; s_mxpc = 1'b1; pc_tgt = 32'h99;
        step();
        w_pc = 1'b0; s_mxpc = 1'b0;
        chk("perr_err",   {31'h0, err}, 32'h1);
        chk("perr_pc",    pc, 32'h40);
        chk("perr_imreq", {31'h0, im_req}, 32'h1);

        // fetch, then jump to all-ones
        im_ack = 1'b1; im_data = 32'h0000_0001;
        step();
        im_ack = 1'b0;
        chk("f3_cnt", {16'h0, fetch_cnt}, 32'h3);
        w_pc = 1'b1; s_mxpc = 1'b1; pc_tgt = 32'hFFFF_FFFF;
        step();
        w_pc = 1'b0; s_mxpc = 1'b0;
        chk("max_pc", pc, 32'hFFFF_FFFF);
        im_ack = 1'b1; im_data = 32'h4100_0000;
        step();
        im_ack = 1'b0;
        chk("f4_type", {29'h0, instr_type}, 32'h2);
        chk("f4_op",   {27'h0, op},         32'h1);
        w_pc = 1'b1;
        step();
        w_pc = 1'b0;
        chk("wrap_pc",   pc, 32'h0);
        chk("err_stick", {31'h0, err}, 32'h1);

        // fetch counter wrap: preload counter to all-ones, then one fetch
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        chk("cnt_pre", {16'h0, fetch_cnt}, 32'h0000_FFFF);
        im_ack = 1'b1; im_data = 32'h0500_0000;
        step();
        im_ack = 1'b0;
        chk("cnt_wrap", {16'h0, fetch_cnt}, 32'h0);

        // reset mid-fetch, with ack asserted during reset
        w_pc = 1'b1;
        step();
        w_pc = 1'b0;
        chk("pre_rst_imreq", {31'h0, im_req}, 32'h1);
        im_ack = 1'b1; im_data = 32'h7700_0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_imreq", {31'h0, im_req}, 32'h0);
        chk("arst_pc",    pc, 32'h0);
        chk("arst_err",   {31'h0, err}, 32'h0);
        chk("arst_cnt",   {16'h0, fetch_cnt}, 32'h0);
        step();
        chk("arst_instr", instr, 32'h0);
        im_ack = 1'b0;
        rst_n = 1'b1;
        step();
        chk("r2_imreq", {31'h0, im_req}, 32'h1);

        // halt word
        im_ack = 1'b1; im_data = 32'hFF00_0000;
        step();
        im_ack = 1'b0;
        chk("halt_halted", {31'h0, halted}, 32'h1);
        chk("halt_valid",  {31'h0, instr_valid}, 32'h1);
        chk("halt_instr",  instr, 32'hFF00_0000);
        chk("halt_type",   {29'h0, instr_type}, 32'h7);
        chk("halt_op",     {27'h0, op}, 32'h1F);
        for (int i = 0; i < 10; i++) begin
            w_pc = (i % 2 == 0);
            im_ack = 1'b1;
            step();
            chk("halt_imreq", {31'h0, im_req}, 32'h0);
            chk("halt_err",   {31'h0, err}, 32'h0);
            chk("halt_pc",    pc, 32'h0);
        end
        w_pc = 1'b0; im_ack = 1'b0;
        chk("halt_cnt", {16'h0, fetch_cnt}, 32'h1);

        rst_n = 1'b0;
        #1;
        chk("halt_clr", {31'h0, halted}, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_RESET, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: HALT_WORD, 8'hFF, instruction bits [31:24] value (type 3'b111, op 5'b11111) that halts fetch.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 W_PC  input  1  one-cycle commit pulse from unit_control; current instruction retired.
REQ-006 S_MXPC  input  1  next-PC select, sampled with W_PC: 0 = PC+1, 1 = PC_TGT.
REQ-007 PC_TGT  input  32  branch/jump target, sampled with W_PC.
REQ-008 IM_ADDR  output  32  instruction memory word address; equals PC.
REQ-009 IM_REQ  output  1  fetch request to instruction memory.
REQ-010 IM_ACK  input  1  memory acknowledge; IM_DATA valid in the same cycle.
REQ-011 IM_DATA  input  32  instruction word from memory.
REQ-012 INSTR  output  32  latched instruction register.
REQ-013 TYPE  output  3  INSTR[31:29], to unit_control type.
REQ-014 OP  output  5  INSTR[28:24], to unit_control op.
REQ-015 INSTR_VALID  output  1  INSTR holds a fetched, not-yet-retired instruction.
REQ-016 PC  output  32  address of INSTR / instruction being fetched.
REQ-017 FETCH_CNT  output  16  count of accepted fetches.
REQ-018 HALTED  output  1  halt word fetched; fetching stopped.
REQ-019 ERR  output  1  sticky protocol error flag.

Function
REQ-020 FSM states SHALL be IDLE, REQ, HOLD, HALT; IDLE entered only by reset.
REQ-021 IDLE SHALL go to REQ on the first clock edge after RESET deasserts, unconditionally.
REQ-022 In REQ, IM_REQ SHALL be 1 and IM_ADDR SHALL equal PC, both stable until IM_ACK is sampled high.
REQ-023 In REQ with IM_ACK=1: INSTR <= IM_DATA, INSTR_VALID <= 1, FETCH_CNT <= FETCH_CNT+1 (16-bit wrap), IM_REQ <= 0; next state HOLD, or HALT if IM_DATA[31:24]==HALT_WORD.
REQ-024 IM_ACK outside REQ SHALL be ignored (no register change).
REQ-025 In HOLD with W_PC=1: PC <= S_MXPC ? PC_TGT : PC+1 (32-bit, 32'hFFFF_FFFF+1 wraps to 0), INSTR_VALID <= 0, next state REQ; IM_REQ asserted the following cycle.
REQ-026 In HOLD with W_PC=0: all outputs hold.
REQ-027 Minimum W_PC-to-next-INSTR_VALID latency SHALL be 2 cycles (1 cycle to REQ, IM_ACK in the first REQ cycle).
REQ-028 W_PC=1 in IDLE or REQ SHALL set ERR and SHALL NOT change PC or state.
REQ-029 HALT: HALTED=1, INSTR_VALID=1 with the halt word, IM_REQ=0; W_PC SHALL be ignored (no ERR); exit only by reset.
REQ-030 TYPE and OP SHALL be combinational slices of INSTR; IM_ADDR and PC the same register.
REQ-031 ERR SHALL remain 1 until reset.

Reset
REQ-032 RESET=0 SHALL immediately force: state IDLE, PC=PC_RESET, INSTR=0, INSTR_VALID=0, IM_REQ=0, FETCH_CNT=0, HALTED=0, ERR=0.
REQ-033 Reset asserted mid-fetch (REQ, awaiting IM_ACK) SHALL abandon the fetch; IM_ACK arriving during reset SHALL be ignored.

Verification
REQ-034 Reset release, IM_ACK=1 on first REQ cycle, IM_DATA=32'h2300_0000 -> IM_ADDR=0, then INSTR_VALID=1, TYPE=3'b001, OP=5'b00011, FETCH_CNT=1.
REQ-035 HOLD, W_PC=1, S_MXPC=0 -> PC=1, IM_REQ=1 next cycle; repeat with S_MXPC=1, PC_TGT=32'h40 -> IM_ADDR=32'h40.
REQ-036 IM_ACK delayed 3 cycles in REQ -> IM_REQ and IM_ADDR stable all 3 cycles, INSTR updated only after ACK.
REQ-037 PC=32'hFFFF_FFFF, W_PC=1, S_MXPC=0 -> PC=0; FETCH_CNT at 16'hFFFF plus one fetch -> 0.
REQ-038 W_PC pulsed during REQ -> ERR=1, PC unchanged; remains 1 through later fetches until RESET=0.
REQ-039 IM_DATA=32'hFF00_0000 fetched -> HALTED=1, IM_REQ stays 0 for 10 cycles despite W_PC pulses; RESET=0 clears HALTED.
